// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 front-end constants and fetch FSM state type
package rv32_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush > stall > load > bubble priority
module if_id_reg #(
    parameter int          XLEN      = rv32_pkg::XLEN,
    parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  logic [31:0]     load_ir,
    input  logic [XLEN-1:0] load_pc,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc1,
    output logic            valid
);

    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc1_q, pc1_d;
    logic            valid_q, valid_d;

    // Next contents: flush kills, stall holds, load captures, otherwise insert a bubble
    always_comb begin
        ir_d    = ir_q;
        pc_d    = pc_q;
        pc1_d   = pc1_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
            ir_d    = NOP_INSTR;
        end else if (!stall) begin
            if (load) begin
                ir_d    = load_ir;
                pc_d    = load_pc;
                pc1_d   = load_pc + XLEN'(32'd4);
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
                ir_d    = NOP_INSTR;
            end
        end
    end

    // Register update with synchronous reset to an invalid NOP
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q    <= NOP_INSTR;
            pc_q    <= '0;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            pc1_q   <= pc1_d;
            valid_q <= valid_d;
        end
    end

    assign ir    = ir_q;
    assign pc    = pc_q;
    assign pc1   = pc1_q;
    assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I fetch: pc, single-outstanding imem handshake, redirect drop, hold buffer
module fetch_stage import rv32_pkg::*; #(
    parameter int              XLEN      = rv32_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(rv32_pkg::RESET_PC),
    parameter logic [31:0]     NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            id_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     IF_ID_IR,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_PC1,
    output logic            IF_ID_valid
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     hold_ir_q, hold_ir_d;

    logic            req_accept;
    logic            rsp_take;
    logic            hold_release;
    logic            if_load;
    logic [31:0]     if_load_ir;
    logic [XLEN-1:0] if_load_pc;
    logic [XLEN-1:0] target_aligned;

    // A new request may chain off a response only when decode can take that response now
    assign imem_req_valid = ~rst & ~PCSrcE &
                            ((state_q == FETCH) |
                             ((state_q == WAIT) & imem_rsp_valid & ~id_stall));
    assign imem_req_addr  = pc_q;
    assign req_accept     = imem_req_valid & imem_req_ready;

    // Response for the live request, not cancelled by a redirect in the same cycle
    assign rsp_take       = (state_q == WAIT) & imem_rsp_valid & ~PCSrcE;
    assign hold_release   = (state_q == HOLD) & ~id_stall & ~PCSrcE;
    assign target_aligned = PCTargetE & ~XLEN'(32'd3);

    // IF/ID load source: buffered word when leaving HOLD, else the arriving response
    always_comb begin
        if_load    = (rsp_take & ~id_stall) | hold_release;
        if_load_ir = imem_rsp_data;
        if_load_pc = inflight_pc_q;
        if (state_q == HOLD) begin
            if_load_ir = hold_ir_q;
            if_load_pc = hold_pc_q;
        end
    end

    // PC, outstanding-request address and hold buffer next values
    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        hold_pc_d     = hold_pc_q;
        hold_ir_d     = hold_ir_q;
        if (PCSrcE) begin
            pc_d = target_aligned;
        end else if (req_accept) begin
            pc_d = pc_q + XLEN'(32'd4);
        end
        if (req_accept) begin
            inflight_pc_d = pc_q;
        end
        if (rsp_take & id_stall) begin
            hold_ir_d = imem_rsp_data;
            hold_pc_d = inflight_pc_q;
        end
    end

    // FSM next state; a redirect only leaves DROP pending if a response is still owed
    always_comb begin
        state_d = state_q;
        if (PCSrcE) begin
            if (((state_q == WAIT) || (state_q == DROP)) && !imem_rsp_valid) begin
                state_d = DROP;
            end else begin
                state_d = FETCH;
            end
        end else begin
            case (state_q)
                FETCH: if (req_accept) state_d = WAIT;
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (id_stall)        state_d = HOLD;
                        else if (req_accept) state_d = WAIT;
                        else                 state_d = FETCH;
                    end
                end
                HOLD:    if (!id_stall) state_d = FETCH;
                DROP:    if (imem_rsp_valid) state_d = FETCH;
                default: state_d = FETCH;
            endcase
        end
    end

    // State and front-end registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            hold_pc_q     <= '0;
            hold_ir_q     <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            hold_pc_q     <= hold_pc_d;
            hold_ir_q     <= hold_ir_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush   (PCSrcE),
        .stall   (id_stall),
        .load    (if_load),
        .load_ir (if_load_ir),
        .load_pc (if_load_pc),
        .ir      (IF_ID_IR),
        .pc      (IF_ID_PC),
        .pc1     (IF_ID_PC1),
        .valid   (IF_ID_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        id_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] IF_ID_IR;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_PC1;
    logic        IF_ID_valid;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    int          budget     = 0;
    int          mem_lat    = 1;
    int          cyc        = 0;
    int          proto_viol = 0;
    int          n_pass     = 0;
    int          n_total    = 0;
    int          n_fail     = 0;
    logic        prev_stall = 1'b0;

    assign imem_req_ready = (budget > 0);

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .PCSrcE         (PCSrcE),
        .PCTargetE      (PCTargetE),
        .id_stall       (id_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .IF_ID_IR       (IF_ID_IR),
        .IF_ID_PC       (IF_ID_PC),
        .IF_ID_PC1      (IF_ID_PC1),
        .IF_ID_valid    (IF_ID_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Negedge sampling: protocol monitor plus scoreboard pop on each fresh IF/ID load
    task automatic sample();
        logic [31:0] e;
        @(negedge clk);
        if (imem_rsp_valid && !rst && dut.state_q == FETCH) proto_viol++;
        if (IF_ID_valid && !prev_stall) begin
            check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_pc", IF_ID_PC, e);
                check("sb_ir", IF_ID_IR, e | 32'h13);
                check("sb_pc1", IF_ID_PC1, e + 32'd4);
            end
        end
    endtask

    // Clock edge plus memory model: accept, queue with latency, return in order
    task automatic clk_edge();
        logic        acc;
        logic [31:0] a;
        acc        = imem_req_valid && imem_req_ready;
        a          = imem_req_addr;
        prev_stall = id_stall;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            pend_q.push_back('{addr: a, due: cyc + mem_lat - 1});
            budget--;
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_q[0].addr | 32'h13;
            void'(pend_q.pop_front());
        end
    endtask

    task automatic step();
        sample();
        clk_edge();
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, observed running expected finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0; id_stall = 1'b0;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        budget = 5; mem_lat = 1;

        // Reset state, with memory ready to prove no request leaks during reset
        sample();
        check("rst_valid", 32'(IF_ID_valid), 32'd0);
        check("rst_ir", IF_ID_IR, NOP_INSTR);
        check("rst_pc", IF_ID_PC, 32'h0);
        check("rst_pc1", IF_ID_PC1, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        clk_edge();
        step();

        // Zero-wait stream of four instructions
        rst = 1'b0; budget = 4; mem_lat = 1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        exp_q.push_back(32'h8); exp_q.push_back(32'hC);
        sample();
        check("t1_req_valid_c0", 32'(imem_req_valid), 32'd1);
        check("t1_req_addr_c0", imem_req_addr, RESET_PC);
        clk_edge();
        sample(); check("t1_valid_c1", 32'(IF_ID_valid), 32'd0); clk_edge();
        sample(); check("t1_valid_c2", 32'(IF_ID_valid), 32'd1); clk_edge();
        step(); step();
        sample(); check("t1_drained_c5", 32'(exp_q.size()), 32'd0); clk_edge();
        sample(); check("t1_bubble_c6", 32'(IF_ID_valid), 32'd0); clk_edge();

        // Ready held low, then slow responses
        rst = 1'b1; step(); rst = 1'b0; budget = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t2_req_valid_stall", 32'(imem_req_valid), 32'd1);
            check("t2_req_addr_stable", imem_req_addr, 32'h0);
            clk_edge();
        end
        budget = 2; mem_lat = 4;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4);
        sample(); check("t2_req_addr_go", imem_req_addr, 32'h0); clk_edge();
        sample(); check("t2_no_req_in_wait", 32'(imem_req_valid), 32'd0); clk_edge();
        drain("t2_drained");
        for (int i = 0; i < 6; i++) step();
        sample(); check("t2_next_addr", imem_req_addr, 32'h8); clk_edge();

        // Redirect while a response is still owed: DROP then fetch aligned target
        mem_lat = 2; budget = 2;
        exp_q.push_back(32'h8);
        sample(); check("t3_req_addr", imem_req_addr, 32'h8); clk_edge();
        step(); step();
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        sample(); check("t3_no_req_redirect", 32'(imem_req_valid), 32'd0); clk_edge();
        PCSrcE = 1'b0;
        sample();
        check("t3_flush_valid", 32'(IF_ID_valid), 32'd0);
        check("t3_flush_ir", IF_ID_IR, NOP_INSTR);
        check("t3_no_req_drop", 32'(imem_req_valid), 32'd0);
        clk_edge();
        budget = 1; mem_lat = 1;
        exp_q.push_back(32'h100);
        sample();
        check("t3_target_valid", 32'(imem_req_valid), 32'd1);
        check("t3_target_addr", imem_req_addr, 32'h100);
        clk_edge();
        drain("t3_drained");

        // Decode stall as the 0x8 response arrives
        rst = 1'b1; step(); rst = 1'b0; budget = 3; mem_lat = 1;
        exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
        step(); step(); step();
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("t4_no_req_hold", 32'(imem_req_valid), 32'd0);
            check("t4_held_pc", IF_ID_PC, 32'h4);
            check("t4_held_valid", 32'(IF_ID_valid), 32'd1);
            clk_edge();
        end
        id_stall = 1'b0;
        sample();
        check("t4_still_pc4", IF_ID_PC, 32'h4);
        check("t4_no_req_release", 32'(imem_req_valid), 32'd0);
        clk_edge();

        // Flush beats stall; back-to-back redirect uses the latest target
        PCSrcE = 1'b1; id_stall = 1'b1; PCTargetE = 32'h40;
        sample();
        check("t4_pc8_after_stall", IF_ID_PC, 32'h8);
        check("t4_drained", 32'(exp_q.size()), 32'd0);
        clk_edge();
        PCSrcE = 1'b1; id_stall = 1'b0; PCTargetE = 32'h81;
        sample();
        check("t5_flush_valid", 32'(IF_ID_valid), 32'd0);
        check("t5_flush_ir", IF_ID_IR, NOP_INSTR);
        check("t5_no_req", 32'(imem_req_valid), 32'd0);
        clk_edge();
        PCSrcE = 1'b0;
        sample(); check("t5_latest_target", imem_req_addr, 32'h80); clk_edge();

        // Reset mid-WAIT, stale response then lands in FETCH
        check("t6_proto_clean", 32'(proto_viol), 32'd0);
        mem_lat = 4; budget = 1;
        sample(); check("t6_req_addr", imem_req_addr, 32'h80); clk_edge();
        rst = 1'b1;
        sample(); check("t6_req_in_rst", 32'(imem_req_valid), 32'd0); clk_edge();
        rst = 1'b0; budget = 0;
        sample();
        check("t6_rst_valid", 32'(IF_ID_valid), 32'd0);
        check("t6_rst_ir", IF_ID_IR, NOP_INSTR);
        check("t6_rst_pc", IF_ID_PC, 32'h0);
        check("t6_rst_pc1", IF_ID_PC1, 32'h0);
        check("t6_rst_addr", imem_req_addr, RESET_PC);
        clk_edge();
        step(); step();
        sample();
        check("t6_stale_flagged", 32'(proto_viol), 32'd1);
        check("t6_stale_ignored", 32'(IF_ID_valid), 32'd0);
        check("t6_addr_after_stale", imem_req_addr, RESET_PC);
        clk_edge();
        budget = 1; mem_lat = 1;
        exp_q.push_back(32'h0);
        step();
        drain("t6_drained");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
RV32I pipeline front end with a PC register, an instruction-memory request/response handshake, and the IF/ID pipeline register. It drives the decode stage (IF_ID_IR, IF_ID_PC, IF_ID_PC1, IF_ID_valid). It accepts branch/jump redirects from execute (PCSrcE, PCTargetE) and a stall from the hazard logic. It tolerates variable memory latency, and drops in-flight fetches on redirect.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
PCSrcE  in  1  redirect request from execute (taken branch/jump)
PCTargetE  in  XLEN  redirect target; bits [1:0] forced to 0
id_stall  in  1  hold IF/ID contents (load-use hazard)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  instruction word returned; in order, one per accepted request
imem_rsp_data  in  32  instruction word
IF_ID_IR  out  32  instruction to decode
IF_ID_PC  out  XLEN  address of IF_ID_IR
IF_ID_PC1  out  XLEN  IF_ID_PC + 4
IF_ID_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Internal state:
  - pc: next address to request.
  - inflight_pc: address of the single outstanding request.
  - hold_ir / hold_pc: one-entry buffer.
  - FSM: FETCH, WAIT, DROP, HOLD.
- Reset values: pc=RESET_PC; state=FETCH; IF_ID_IR=NOP_INSTR; IF_ID_PC=0; IF_ID_PC1=0; IF_ID_valid=0; imem_req_valid=0 while rst is high.
- Request rule: imem_req_valid = ~rst & ~PCSrcE & (state==FETCH | (state==WAIT & imem_rsp_valid & ~id_stall)).
- Request acceptance: a request is accepted when valid & ready. On acceptance, inflight_pc<=pc and pc<=pc+4 (wraps mod 2^XLEN). At most one request is outstanding.
- FETCH:
  - Accepted: go to WAIT.
  - Not accepted: stay in FETCH.
  - imem_rsp_valid in FETCH is a protocol violation; it is ignored and flagged by a bench assertion.
- WAIT with rsp_valid and ~PCSrcE:
  - ~id_stall: load IF/ID with {rsp_data, inflight_pc, inflight_pc+4, valid=1}. Next state is WAIT if the chained request was accepted, otherwise FETCH.
  - id_stall: capture rsp into hold_*; go to HOLD.
- WAIT without rsp_valid: stay in WAIT.
- HOLD:
  - ~id_stall: load IF/ID from hold_*; go to FETCH.
  - id_stall: stay in HOLD.
- DROP:
  - rsp_valid: discard the response; go to FETCH.
  - Otherwise stay in DROP.
- Redirect (PCSrcE=1) overrides every state:
  - pc<=PCTargetE & ~3; no request is issued that cycle.
  - WAIT without rsp goes to DROP. WAIT with rsp, HOLD, and FETCH go to FETCH (the response or buffer is discarded).
  - DROP with rsp goes to FETCH; DROP without rsp stays in DROP.
  - A repeated redirect uses the latest target.
- IF/ID register priority: rst > PCSrcE (IF_ID_valid<=0, IF_ID_IR<=NOP_INSTR) > id_stall (hold all) > load > bubble.
  - Bubble: IF_ID_valid<=0, IF_ID_IR<=NOP_INSTR, PC fields unchanged.
- Latency and throughput: with zero-wait memory (rsp one cycle after acceptance), an instruction reaches IF/ID 2 cycles after request; steady throughput is 1 instruction/cycle.
- Redirect penalty: first target instruction appears in IF/ID 3 cycles after PCSrcE with zero-wait memory, longer if a DROP is pending.

Decomposition:
- Shared package rv32_pkg: XLEN, NOP_INSTR, RESET_PC defaults, and the fetch_state_t enum {FETCH, WAIT, DROP, HOLD}.
- One sub-module: if_id_reg, holding the IF/ID register with the flush > stall > load > bubble priority.
- FSM, pc and hold buffer stay in fetch_stage.

Test Plan:
- Reset then zero-wait memory returning word=addr|0x13 -> IF_ID_PC sequence 0,4,8,12 on consecutive cycles; first IF_ID_valid=1 on cycle 2 after rst deasserts; IF_ID_PC1=IF_ID_PC+4.
- req_ready low 3 cycles, rsp delayed 4 cycles -> imem_req_addr stable at 0x0 while waiting; single IF/ID load per response; no duplicate or skipped PCs.
- PCSrcE=1, PCTargetE=0x103 while in WAIT, rsp arrives next cycle -> that response discarded; next request addr 0x100; IF_ID_valid=0 in the flush cycle.
- id_stall high 3 cycles as rsp for 0x8 arrives -> IF/ID holds 0x4 instruction; 0x8 appears in the cycle after stall drops; no request issued during HOLD.
- PCSrcE and id_stall both high with IF/ID valid -> flush wins: IF_ID_valid=0, IF_ID_IR=0x00000013.
- Assert rst mid-WAIT, then a stale rsp arrives while in FETCH -> outputs at reset values; next request addr=RESET_PC; protocol assertion flags the stale rsp.
